// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, one-hot T-states and
// the internal control-word layout (every field asserted-high).
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // Active-low pins are kept asserted-high here and inverted at the top level.
  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot ring counter (T1..T6) with a hold input that freezes it.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [5:0] t_state
);

  logic [5:0] state_reg;
  logic [5:0] state_next;

  always_comb begin
    state_next = state_reg;
    if (!hold) begin
      state_next = {state_reg[4:0], state_reg[5]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= T1;
    end else begin
      state_reg <= state_next;
    end
  end

  assign t_state = state_reg;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: ring counter plus combinational decode of
// T-state and opcode into the bus/register control lines, with halt latch.
module sap1_controller
  import sap1_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  output logic [5:0]      t_state,
  output logic            cp,
  output logic            ep,
  output logic            ea,
  output logic            eu,
  output logic            su,
  output logic            n_lm,
  output logic            n_ce,
  output logic            n_li,
  output logic            n_ei,
  output logic            n_la,
  output logic            n_lb,
  output logic            n_lo,
  output logic            hlt
);

  logic  halted_reg;
  logic  halt_now;
  logic  hold;
  ctrl_t cw;

  // Hold must already be asserted in the HLT T4 cycle so the ring never leaves T4.
  assign halt_now = (t_state == T4) && (opcode == OP_HLT);
  assign hold     = halted_reg || halt_now;

  sap1_ring_counter u_ring (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold),
    .t_state (t_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_reg <= 1'b0;
    end else if (halt_now) begin
      halted_reg <= 1'b1;
    end
  end

  always_comb begin
    cw = CTRL_IDLE;
    if (!rst && !halted_reg) begin
      case (t_state)
        T1: begin cw.ep = 1'b1; cw.lm = 1'b1; end
        T2: cw.cp = 1'b1;
        T3: begin cw.ce = 1'b1; cw.li = 1'b1; end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD: begin cw.ei = 1'b1; cw.lm = 1'b1; end
            OP_SUB:         begin cw.ei = 1'b1; cw.lm = 1'b1; cw.su = 1'b1; end
            OP_OUT:         begin cw.ea = 1'b1; cw.lo = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin cw.ce = 1'b1; cw.la = 1'b1; end
            OP_ADD: begin cw.ce = 1'b1; cw.lb = 1'b1; end
            OP_SUB: begin cw.ce = 1'b1; cw.lb = 1'b1; cw.su = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin cw.eu = 1'b1; cw.la = 1'b1; end
            OP_SUB: begin cw.eu = 1'b1; cw.la = 1'b1; cw.su = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign cp   = cw.cp;
  assign ep   = cw.ep;
  assign ea   = cw.ea;
  assign eu   = cw.eu;
  assign su   = cw.su;
  assign n_lm = ~cw.lm;
  assign n_ce = ~cw.ce;
  assign n_li = ~cw.li;
  assign n_ei = ~cw.ei;
  assign n_la = ~cw.la;
  assign n_lb = ~cw.lb;
  assign n_lo = ~cw.lo;
  assign hlt  = !rst && hold;

endmodule

// File: doc/sap1_controller.md
SAP1_CONTROLLER -- requirements
Module: sap1_controller

Interface
REQ-001 The block SHALL have parameter OP_W, default 4, giving the opcode width; only 4 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port opcode, input, OP_W bits: instruction-register upper nibble, valid and stable during T4-T6.
REQ-005 The block SHALL have port t_state, output, 6 bits: one-hot ring state, bit0 = T1 through bit5 = T6.
REQ-006 The block SHALL have ports cp, ep, ea, eu, su, output, 1 bit each, active-high: PC increment, PC drive, accumulator drive, adder drive, subtract select.
REQ-007 The block SHALL have ports n_lm, n_ce, n_li, n_ei, n_la, n_lb, n_lo, output, 1 bit each, active-low: MAR load, RAM drive, IR load, IR drive, A load, B load, output-register load.
REQ-008 The block SHALL have port hlt, output, 1 bit: high while halted.

Function
REQ-009 The ring counter SHALL advance T1->T2->T3->T4->T5->T6->T1, one state per clk edge, exactly one bit set.
REQ-010 Control outputs SHALL be combinational decode of t_state and opcode; an inactive control is 0 for active-high and 1 for active-low.
REQ-011 Fetch, independent of opcode: T1 ep=1, n_lm=0; T2 cp=1; T3 n_ce=0, n_li=0.
REQ-012 LDA (0000): T4 n_ei=0, n_lm=0; T5 n_ce=0, n_la=0; T6 all inactive.
REQ-013 ADD (0001): T4 n_ei=0, n_lm=0; T5 n_ce=0, n_lb=0; T6 eu=1, n_la=0.
REQ-014 SUB (0010): same as ADD, plus su=1 throughout T4-T6.
REQ-015 OUT (1110): T4 ea=1, n_lo=0; T5-T6 all inactive.
REQ-016 HLT (1111): in T4, hlt=1 combinationally; at the next edge the halted flag SHALL set; the counter SHALL then hold at T4 with all controls inactive and hlt=1 until rst.
REQ-017 Any other opcode SHALL be a NOP: T4-T6 all inactive, and the ring SHALL continue.
REQ-018 At most one bus driver (ep, n_ce low, n_ei low, ea, eu) SHALL be active in any state.
REQ-019 Opcode changes during T1-T3 SHALL have no effect on outputs.

Reset
REQ-020 When rst=1 at an edge, t_state SHALL become 6'b000001 and the halted flag SHALL clear.
REQ-021 While rst=1, all controls SHALL be inactive and hlt=0.
REQ-022 The first fetch SHALL begin with T1 controls on the cycle after rst deasserts.
REQ-023 rst SHALL override halt and any mid-instruction state.

Structure
REQ-024 A shared package sap1_pkg SHALL hold the opcode constants (LDA, ADD, SUB, OUT, HLT), the one-hot T-state constants and the control-word bit ordering.
REQ-025 The ring counter with hold input SHALL be a sub-module, sap1_ring_counter; decode and the halted flag SHALL live in sap1_controller.

Verification
REQ-026 The bench SHALL cover: rst=1 for 2 cycles, then release -> t_state=000001 with ep=1, n_lm=0; next cycle t_state=000010 with cp=1.
REQ-027 The bench SHALL cover: opcode=0001 over 6 cycles -> T4 n_ei=0, n_lm=0; T5 n_ce=0, n_lb=0; T6 eu=1, n_la=0, su=0; then back to T1.
REQ-028 The bench SHALL cover: opcode=0010 -> same as ADD with su=1 in T4, T5 and T6 only.
REQ-029 The bench SHALL cover: opcode=1111 -> hlt=1 at T4, and t_state stays 001000 for 20 cycles with all controls inactive; then rst=1 -> t_state=000001 and hlt=0.
REQ-030 The bench SHALL cover: opcode=0111 (undefined) -> T4-T6 all inactive and the ring wraps to T1; opcode toggled during T1-T3 -> no output change.
REQ-031 The bench SHALL cover: rst asserted in T5 of LDA -> next cycle t_state=000001 and n_la=1; a one-hot and single-bus-driver assertion SHALL hold every cycle.
